// File: rtl/fsstep_gen.sv
`default_nettype none
// ============================================================================
//  Module   : fsstep_gen
//  Purpose  : Per-axis stepper pulse generator for one motor-router slot.
//             Accepts a move command over valid/ready, emits drive pulses at
//             the commanded half-period and tracks a signed step position.
//             A move stops on step count, abort or zero-position detect.
//             All stop decisions are taken only at the end of a low phase,
//             so a drive pulse is never truncated.
//  Ports    : clk, reset (sync, active-high)
//             cmd_valid/cmd_ready, cmd_dir, cmd_steps, cmd_half_period,
//             cmd_to_zero        - move command
//             abort              - level, stops at end of current pulse
//             cfg_xen/xrst/ms    - driver controls, registered to m_*
//             m_zpd              - async zero-position sensor
//             m_drive, m_dir     - step pulse and direction
//             busy, done, done_reason, position - status
//  Options  : FSSTEP_GEN_RAMP_EN - start at 4x half-period and accelerate
//             by C_RAMP_DELTA per step down to the commanded half-period.
//  Revision : 1.0 - initial release
// ============================================================================
module fsstep_gen #(
    parameter int C_MICROSTEP_WIDTH   = 3,
    parameter int C_STEP_NUMBER_WIDTH = 16,
    parameter int C_SPEED_DATA_WIDTH  = 16,
    parameter int C_POSITION_WIDTH    = 32,
    parameter int C_RAMP_DELTA        = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic                               cmd_dir,
    input  logic [C_STEP_NUMBER_WIDTH-1:0]     cmd_steps,
    input  logic [C_SPEED_DATA_WIDTH-1:0]      cmd_half_period,
    input  logic                               cmd_to_zero,
    input  logic                               abort,
    input  logic                               cfg_xen,
    input  logic                               cfg_xrst,
    input  logic [C_MICROSTEP_WIDTH-1:0]       cfg_ms,
    input  logic                               m_zpd,
    output logic                               m_xen,
    output logic                               m_xrst,
    output logic [C_MICROSTEP_WIDTH-1:0]       m_ms,
    output logic                               m_drive,
    output logic                               m_dir,
    output logic                               busy,
    output logic                               done,
    output logic [1:0]                         done_reason,
    output logic signed [C_POSITION_WIDTH-1:0] position
);

    localparam logic [C_SPEED_DATA_WIDTH-1:0]  c_HP_ONE   = C_SPEED_DATA_WIDTH'(1);
    localparam logic [C_STEP_NUMBER_WIDTH-1:0] c_STEP_ONE = C_STEP_NUMBER_WIDTH'(1);
    localparam logic [C_POSITION_WIDTH-1:0]    c_POS_ONE  = C_POSITION_WIDTH'(1);
    localparam logic [1:0] c_REASON_COUNT = 2'd0;
    localparam logic [1:0] c_REASON_ZPD   = 2'd1;
    localparam logic [1:0] c_REASON_ABORT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_HIGH   = 3'd2,
        S_LOW    = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t                           r_state, w_state_next;
    logic                             r_drive, r_dir, r_to_zero, r_done;
    logic [1:0]                       r_reason, w_reason;
    logic [C_STEP_NUMBER_WIDTH-1:0]   r_remaining;
    logic [C_SPEED_DATA_WIDTH-1:0]    r_hp, r_cur_hp, r_cnt;
    logic [C_POSITION_WIDTH-1:0]      r_position;
    logic                             r_xen, r_xrst;
    logic [C_MICROSTEP_WIDTH-1:0]     r_ms;
    logic                             r_zpd_meta, r_zpd_s;

    logic                             w_accept, w_start_pulse, w_home_zero, w_enter_finish;
    logic                             w_phase_end;
    logic [C_SPEED_DATA_WIDTH-1:0]    w_hp_clamped, w_hp_start, w_ramp_next, w_pulse_hp;

    assign w_hp_clamped = (cmd_half_period == '0) ? c_HP_ONE : cmd_half_period;
    assign w_phase_end  = (r_cnt == '0);

`ifdef FSSTEP_GEN_RAMP_EN
    localparam logic [C_SPEED_DATA_WIDTH-1:0] c_RAMP_DELTA = C_SPEED_DATA_WIDTH'(C_RAMP_DELTA);
    logic [C_SPEED_DATA_WIDTH+1:0] w_hp_x4;
    logic [C_SPEED_DATA_WIDTH-1:0] w_ramp_gap;
    assign w_hp_x4    = {2'b00, w_hp_clamped} << 2;
    // Saturate the starting half-period at the counter's full scale.
    assign w_hp_start = (w_hp_x4[C_SPEED_DATA_WIDTH+1:C_SPEED_DATA_WIDTH] != 2'b00)
                        ? {C_SPEED_DATA_WIDTH{1'b1}} : w_hp_x4[C_SPEED_DATA_WIDTH-1:0];
    // Gap-based compare avoids overflow of r_hp + delta near full scale.
    assign w_ramp_gap  = r_cur_hp - r_hp;
    assign w_ramp_next = (w_ramp_gap > c_RAMP_DELTA) ? (r_cur_hp - c_RAMP_DELTA) : r_hp;
`else
    assign w_hp_start  = w_hp_clamped;
    assign w_ramp_next = r_cur_hp;
`endif

    // Ramp step applies only between pulses, never to the first pulse.
    assign w_pulse_hp = (r_state == S_LOW) ? w_ramp_next : r_cur_hp;

    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_start_pulse = 1'b0;
        w_home_zero   = 1'b0;
        w_reason      = r_reason;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    if (cmd_to_zero && r_zpd_s) begin
                        w_state_next = S_FINISH;
                        w_reason     = c_REASON_ZPD;
                        w_home_zero  = 1'b1;
                    end else if (cmd_steps == '0) begin
                        w_state_next = S_FINISH;
                        w_reason     = c_REASON_COUNT;
                    end else begin
                        w_state_next = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                w_state_next  = S_HIGH;
                w_start_pulse = 1'b1;
            end
            S_HIGH: begin
                if (w_phase_end) begin
                    w_state_next = S_LOW;
                end
            end
            S_LOW: begin
                if (w_phase_end) begin
                    // Priority: zero-position detect, then abort, then count.
                    if (r_to_zero && r_zpd_s) begin
                        w_state_next = S_FINISH;
                        w_reason     = c_REASON_ZPD;
                        w_home_zero  = 1'b1;
                    end else if (abort) begin
                        w_state_next = S_FINISH;
                        w_reason     = c_REASON_ABORT;
                    end else if (r_remaining == '0) begin
                        w_state_next = S_FINISH;
                        w_reason     = c_REASON_COUNT;
                    end else begin
                        w_state_next  = S_HIGH;
                        w_start_pulse = 1'b1;
                    end
                end
            end
            S_FINISH: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_enter_finish = (w_state_next == S_FINISH) && (r_state != S_FINISH);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_drive     <= 1'b0;
            r_dir       <= 1'b0;
            r_to_zero   <= 1'b0;
            r_done      <= 1'b0;
            r_reason    <= c_REASON_COUNT;
            r_remaining <= '0;
            r_hp        <= c_HP_ONE;
            r_cur_hp    <= c_HP_ONE;
            r_cnt       <= '0;
            r_position  <= '0;
            r_xen       <= 1'b1;
            r_xrst      <= 1'b0;
            r_ms        <= '0;
            r_zpd_meta  <= 1'b0;
            r_zpd_s     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_drive    <= (w_state_next == S_HIGH);
            r_done     <= (w_state_next == S_FINISH);
            r_xen      <= cfg_xen;
            r_xrst     <= cfg_xrst;
            r_ms       <= cfg_ms;
            r_zpd_meta <= m_zpd;
            r_zpd_s    <= r_zpd_meta;

            if (w_accept) begin
                r_to_zero   <= cmd_to_zero;
                r_remaining <= cmd_steps;
                r_hp        <= w_hp_clamped;
                r_cur_hp    <= w_hp_start;
                // Direction changes on the accept edge so it is stable for the
                // whole SETUP cycle before the first rising drive.
                if (w_state_next == S_SETUP) begin
                    r_dir <= cmd_dir;
                end
            end

            if (w_enter_finish) begin
                r_reason <= w_reason;
            end

            if (w_home_zero) begin
                r_position <= '0;
            end else if (w_start_pulse) begin
                r_position <= r_dir ? (r_position + c_POS_ONE) : (r_position - c_POS_ONE);
            end

            if (w_start_pulse) begin
                r_remaining <= r_remaining - c_STEP_ONE;
                r_cur_hp    <= w_pulse_hp;
                r_cnt       <= w_pulse_hp - c_HP_ONE;
            end else if ((r_state == S_HIGH) && w_phase_end) begin
                r_cnt <= r_cur_hp - c_HP_ONE;
            end else if ((r_state == S_HIGH) || (r_state == S_LOW)) begin
                r_cnt <= r_cnt - c_HP_ONE;
            end
        end
    end

    assign cmd_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign done_reason = r_reason;
    assign position    = r_position;
    assign m_drive     = r_drive;
    assign m_dir       = r_dir;
    assign m_xen       = r_xen;
    assign m_xrst      = r_xrst;
    assign m_ms        = r_ms;

endmodule
`default_nettype wire

// File: tb/tb_fsstep_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fsstep_gen
//  Purpose  : Self-checking bench for fsstep_gen. Directed moves; the expected
//             done reason and final position are queued when a command is
//             accepted and compared when done pulses. Drive pulse widths and
//             counts are captured on the falling clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fsstep_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_dir, cmd_to_zero, abort;
    logic [15:0] cmd_steps, cmd_half_period;
    logic        cfg_xen, cfg_xrst;
    logic [2:0]  cfg_ms, m_ms;
    logic        m_zpd, m_xen, m_xrst, m_drive, m_dir, busy, done;
    logic [1:0]  done_reason;
    logic [31:0] position;

    always #5 clk = ~clk;

    fsstep_gen dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_dir         (cmd_dir),
        .cmd_steps       (cmd_steps),
        .cmd_half_period (cmd_half_period),
        .cmd_to_zero     (cmd_to_zero),
        .abort           (abort),
        .cfg_xen         (cfg_xen),
        .cfg_xrst        (cfg_xrst),
        .cfg_ms          (cfg_ms),
        .m_zpd           (m_zpd),
        .m_xen           (m_xen),
        .m_xrst          (m_xrst),
        .m_ms            (m_ms),
        .m_drive         (m_drive),
        .m_dir           (m_dir),
        .busy            (busy),
        .done            (done),
        .done_reason     (done_reason),
        .position        (position)
    );

    typedef struct {
        logic [1:0]  reason;
        logic [31:0] pos;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    logic prev_drive  = 1'b0;
    int   rises       = 0;
    int   first_rise  = -1;
    int   hi_len      = 0;
    int   lo_len      = 0;
    int   hi_q[$];
    int   lo_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and update drive-pulse statistics.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (m_drive && !prev_drive) begin
            rises++;
            if (first_rise < 0) first_rise = cyc;
            if (rises > 1) lo_q.push_back(lo_len);
            hi_len = 1;
        end else if (m_drive) begin
            hi_len++;
        end else if (prev_drive) begin
            hi_q.push_back(hi_len);
            lo_len = 1;
        end else begin
            lo_len++;
        end
        prev_drive = m_drive;
    endtask

    task automatic clear_stats();
        rises      = 0;
        first_rise = -1;
        hi_q.delete();
        lo_q.delete();
    endtask

    task automatic send(input logic dir, input logic [15:0] steps, input logic [15:0] hp,
                        input logic tz, input logic [1:0] exp_reason, input logic [31:0] exp_pos,
                        input bit expect_done, output int acc_cyc);
        exp_t e;
        clear_stats();
        check("ready_before_cmd", 64'(cmd_ready), 64'd1);
        cmd_dir         = dir;
        cmd_steps       = steps;
        cmd_half_period = hp;
        cmd_to_zero     = tz;
        cmd_valid       = 1'b1;
        acc_cyc         = cyc;
        if (expect_done) begin
            e.reason = exp_reason;
            e.pos    = exp_pos;
            sb.push_back(e);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string tag, output int n);
        exp_t e;
        n = 0;
        while (!done && n < bound) begin
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        check({tag, "_done_seen"}, 64'(done), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_reason"}, 64'(done_reason), 64'(e.reason));
            check({tag, "_position"}, 64'(position), 64'(e.pos));
        end
        tick();
        check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        check({tag, "_reason_held"}, 64'(done_reason), 64'(e.reason));
    endtask

    initial begin
        int acc;
        int n;
        reset           = 1'b1;
        cmd_valid       = 1'b0;
        cmd_dir         = 1'b0;
        cmd_steps       = '0;
        cmd_half_period = '0;
        cmd_to_zero     = 1'b0;
        abort           = 1'b0;
        cfg_xen         = 1'b0;
        cfg_xrst        = 1'b1;
        cfg_ms          = 3'd5;
        m_zpd           = 1'b0;
        repeat (3) tick();

        // Reset state (cfg inputs deliberately non-default)
        check("rst_drive", 64'(m_drive), 64'd0);
        check("rst_dir", 64'(m_dir), 64'd0);
        check("rst_xen", 64'(m_xen), 64'd1);
        check("rst_xrst", 64'(m_xrst), 64'd0);
        check("rst_ms", 64'(m_ms), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_reason", 64'(done_reason), 64'd0);
        check("rst_position", 64'(position), 64'd0);
        check("rst_ready", 64'(cmd_ready), 64'd1);

        reset = 1'b0;
        tick();
        check("cfg_xen", 64'(m_xen), 64'd0);
        check("cfg_xrst", 64'(m_xrst), 64'd1);
        check("cfg_ms", 64'(m_ms), 64'd5);
        cfg_ms = 3'd2;
        tick();
        check("cfg_ms_follow", 64'(m_ms), 64'd2);

        // Test 1: 3 pulses, 2 high / 2 low, positive direction
        send(1'b1, 16'd3, 16'd2, 1'b0, 2'd0, 32'd3, 1'b1, acc);
        check("t1_dir_setup", 64'(m_dir), 64'd1);
        wait_done(100, "t1", n);
        check("t1_rises", 64'(rises), 64'd3);
        check("t1_first_rise_latency", 64'(first_rise - acc), 64'd2);
        check("t1_hi_count", 64'(hi_q.size()), 64'd3);
        foreach (hi_q[i]) check("t1_hi_width", 64'(hi_q[i]), 64'd2);
        check("t1_lo_count", 64'(lo_q.size()), 64'd2);
        foreach (lo_q[i]) check("t1_lo_width", 64'(lo_q[i]), 64'd2);

        // Test 2: zero steps finishes without any pulse
        send(1'b1, 16'd0, 16'd5, 1'b0, 2'd0, 32'd3, 1'b1, acc);
        wait_done(2, "t2", n);
        check("t2_latency", 64'(n <= 2), 64'd1);
        check("t2_rises", 64'(rises), 64'd0);

        // Test 3: homing move stopped by zero-position sensor
        send(1'b1, 16'd100, 16'd1, 1'b1, 2'd1, 32'd0, 1'b1, acc);
        n = 0;
        while (rises < 5 && n < 100) begin
            tick();
            n++;
        end
        check("t3_reached_pulse5", 64'(rises), 64'd5);
        m_zpd = 1'b1;
        wait_done(4, "t3", n);
        m_zpd = 1'b0;
        repeat (2) tick();

        // Test 5: negative step from 0 wraps to all ones; commands ignored while busy
        send(1'b0, 16'd1, 16'd2, 1'b0, 2'd0, 32'hFFFF_FFFF, 1'b1, acc);
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_steps = 16'd7;
        tick();
        check("t5_ready_busy", 64'(cmd_ready), 64'd0);
        check("t5_dir", 64'(m_dir), 64'd0);
        wait_done(50, "t5", n);
        repeat (3) tick();
        check("t5_ignored_not_busy", 64'(busy), 64'd0);
        check("t5_position_kept", 64'(position), 64'hFFFF_FFFF);
        check("t5_rises", 64'(rises), 64'd1);

        // Test 4: abort during pulse 2 high completes pulse 2 only
        send(1'b1, 16'd10, 16'd4, 1'b0, 2'd2, 32'd1, 1'b1, acc);
        n = 0;
        while (rises < 2 && n < 100) begin
            tick();
            n++;
        end
        check("t4_at_pulse2", 64'(m_drive), 64'd1);
        abort = 1'b1;
        wait_done(100, "t4", n);
        abort = 1'b0;
        check("t4_rises", 64'(rises), 64'd2);
        check("t4_hi_count", 64'(hi_q.size()), 64'd2);
        foreach (hi_q[i]) check("t4_hi_width", 64'(hi_q[i]), 64'd4);

        // Test 6: reset mid-HIGH
        send(1'b1, 16'd10, 16'd3, 1'b0, 2'd0, 32'd0, 1'b0, acc);
        n = 0;
        while (!m_drive && n < 20) begin
            tick();
            n++;
        end
        check("t6_in_high", 64'(m_drive), 64'd1);
        reset = 1'b1;
        tick();
        check("t6_drive", 64'(m_drive), 64'd0);
        check("t6_xen", 64'(m_xen), 64'd1);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_position", 64'(position), 64'd0);
        check("t6_done", 64'(done), 64'd0);
        reset = 1'b0;
        tick();
        check("t6_xen_follow", 64'(m_xen), 64'd0);

        // Follow-up move from cleared position, half-period 0 clamps to 1
        send(1'b1, 16'd2, 16'd0, 1'b0, 2'd0, 32'd2, 1'b1, acc);
        wait_done(50, "t7", n);
        check("t7_rises", 64'(rises), 64'd2);
        foreach (hi_q[i]) check("t7_hi_width", 64'(hi_q[i]), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
